stack_access_unit: RTL and testbench

Synchronous stack memory sequencer between the instruction decoder and `stack_pointer_ctl`. It accepts one PUSH/POP/CALL/RET request at a time and samples the current 8-bit stack pointer. It moves the 16-bit operand as two byte transfers on the byte-wide data memory port. When the transfer finishes, it strobes `stack_command`/`stack_ctl` so the pointer controller commits the ±2 adjustment. POP data goes to the register file; RET data goes to jump control.

---
 rtl/stack_pkg.sv | 30 +++
 rtl/stack_access_unit_bound_check.sv | 27 ++
 rtl/stack_access_unit.sv | 212 +++++++++++++++++++++
 tb/tb_stack_access_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack access unit: opcodes, FSM states,
// default stack bounds and a small opcode classification helper.
package stack_pkg;

  localparam logic [1:0] OP_PUSH = 2'h0;
  localparam logic [1:0] OP_POP  = 2'h1;
  localparam logic [1:0] OP_CALL = 2'h2;
  localparam logic [1:0] OP_RET  = 2'h3;

  // Empty-stack pointer and lowest legal slot; the stack grows downward.
  localparam logic [7:0] DEF_STACK_TOP    = 8'h3E;
  localparam logic [7:0] DEF_STACK_BOTTOM = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_RD_LO,
    S_RD_HI,
    S_RD_CAP,
    S_DONE,
    S_ERR
  } stack_state_t;

  // PUSH and CALL store a 16-bit value; POP and RET load one.
  function automatic logic is_write_op(input logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

endpackage

// File: rtl/stack_access_unit_bound_check.sv
// Combinational stack bound checker. Evaluates the request opcode against
// the current stack pointer using 9-bit arithmetic so sp+2 cannot wrap.
// Only instantiated when STACK_FAULT_EN is defined.
module stack_bound_check
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_TOP    = DEF_STACK_TOP,
  parameter logic [7:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
  input  logic [1:0] op_code,
  input  logic [7:0] sp_in,
  output logic       fault
);

  logic [8:0] sp_ext;

  // Writes fault outside [bottom, top]; reads fault when nothing is stacked.
  always_comb begin
    sp_ext = {1'b0, sp_in};
    if (is_write_op(op_code)) begin
      fault = (sp_ext < {1'b0, STACK_BOTTOM}) || (sp_ext > {1'b0, STACK_TOP});
    end else begin
      fault = (sp_ext + 9'd2) > {1'b0, STACK_TOP};
    end
  end

endmodule

// File: rtl/stack_access_unit.sv
// Stack memory sequencer: accepts one PUSH/POP/CALL/RET at a time, moves the
// 16-bit operand as two byte transfers, then strobes stack_command so the
// pointer controller commits the +/-2 adjustment.
// Optional feature macro: STACK_FAULT_EN enables bound checking, the ERR
// state, op_err and the sticky stack_fault flag.
module stack_access_unit
  import stack_pkg::*;
#(
  parameter logic [7:0] STACK_TOP    = DEF_STACK_TOP,
  parameter logic [7:0] STACK_BOTTOM = DEF_STACK_BOTTOM
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [15:0] push_data,
  input  logic [7:0]  sp_in,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] pop_data,
  output logic        pop_valid,
  output logic        jump_valid,
  output logic [15:0] jump_addr,
  output logic        stack_command,
  output logic [1:0]  stack_ctl,
  output logic        op_done,
  output logic        op_err,
  output logic        stack_fault
);

  stack_state_t state_q, state_d;
  logic [7:0]   sp_q, sp_d;
  logic [15:0]  data_q, data_d;
  logic [1:0]   ctl_q, ctl_d;
  logic [7:0]   rd_lo_q, rd_lo_d;
  logic [15:0]  pop_data_q, pop_data_d;
  logic         req_fault;
  logic         accept;

  assign accept = op_valid && (state_q == S_IDLE);

`ifdef STACK_FAULT_EN
  logic fault_q, fault_d;

  stack_bound_check #(
    .STACK_TOP    (STACK_TOP),
    .STACK_BOTTOM (STACK_BOTTOM)
  ) u_bound_check (
    .op_code (op_code),
    .sp_in   (sp_in),
    .fault   (req_fault)
  );

  assign stack_fault = fault_q;
`else
  // Bounds only matter to the fault checker; keep them referenced here.
  logic [15:0] unused_cfg;
  assign unused_cfg  = {STACK_TOP, STACK_BOTTOM};
  assign req_fault   = 1'b0;
  assign stack_fault = 1'b0;
`endif

  // State and datapath registers; reset aborts any transfer in flight.
  // NOTE: every flop here is a plain register with a known reset value and
  // is updated with <= so all of them sample the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sp_q       <= '0;
      data_q     <= '0;
      ctl_q      <= '0;
      rd_lo_q    <= '0;
      pop_data_q <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      data_q     <= data_d;
      ctl_q      <= ctl_d;
      rd_lo_q    <= rd_lo_d;
      pop_data_q <= pop_data_d;
    end
  end

`ifdef STACK_FAULT_EN
  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  // Set the flag on the acceptance edge so it is visible during ERR.
  always_comb begin
    fault_d = fault_q;
    if (accept && req_fault) begin
      fault_d = 1'b1;
    end
  end
`endif

  // Next-state logic: write path, read path, or straight to ERR.
  // NOTE: state_d gets a default before the case so no branch can leave it
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (req_fault) begin
`ifdef STACK_FAULT_EN
            state_d = S_ERR;
`else
            state_d = S_IDLE;
`endif
          end else if (is_write_op(op_code)) begin
            state_d = S_WR_LO;
          end else begin
            state_d = S_RD_LO;
          end
        end
      end
      S_WR_LO:  state_d = S_WR_HI;
      S_WR_HI:  state_d = S_DONE;
      S_RD_LO:  state_d = S_RD_HI;
      S_RD_HI:  state_d = S_RD_CAP;
      S_RD_CAP: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture and read-data assembly; pop_data updates only as a
  // complete word so it holds the previous result until the next POP/RET.
  always_comb begin
    sp_d       = sp_q;
    data_d     = data_q;
    ctl_d      = ctl_q;
    rd_lo_d    = rd_lo_q;
    pop_data_d = pop_data_q;
    if (accept) begin
      sp_d   = sp_in;
      data_d = push_data;
      ctl_d  = op_code;
    end
    if (state_q == S_RD_HI) begin
      rd_lo_d = mem_rdata;
    end
    if (state_q == S_RD_CAP) begin
      pop_data_d = {mem_rdata, rd_lo_q};
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    op_ready      = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_re        = 1'b0;
    pop_valid     = 1'b0;
    jump_valid    = 1'b0;
    stack_command = 1'b0;
    op_done       = 1'b0;
    op_err        = 1'b0;
    unique case (state_q)
      S_IDLE: op_ready = 1'b1;
      S_WR_LO: begin
        mem_addr  = sp_q;
        mem_wdata = data_q[7:0];
        mem_we    = 1'b1;
      end
      S_WR_HI: begin
        mem_addr  = sp_q + 8'd1;
        mem_wdata = data_q[15:8];
        mem_we    = 1'b1;
      end
      S_RD_LO: begin
        mem_addr = sp_q + 8'd2;
        mem_re   = 1'b1;
      end
      S_RD_HI: begin
        mem_addr = sp_q + 8'd3;
        mem_re   = 1'b1;
      end
      S_RD_CAP: ;
      S_DONE: begin
        stack_command = 1'b1;
        op_done       = 1'b1;
        pop_valid     = (ctl_q == OP_POP);
        jump_valid    = (ctl_q == OP_RET);
      end
`ifdef STACK_FAULT_EN
      S_ERR: begin
        op_done = 1'b1;
        op_err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign pop_data  = pop_data_q;
  assign jump_addr = pop_data_q;
  assign stack_ctl = ctl_q;

endmodule

// File: tb/tb_stack_access_unit.sv
// Directed testbench for stack_access_unit with a byte-wide memory model.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_stack_access_unit;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_code;
  logic [15:0] push_data;
  logic [7:0]  sp_in;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic        jump_valid;
  logic [15:0] jump_addr;
  logic        stack_command;
  logic [1:0]  stack_ctl;
  logic        op_done;
  logic        op_err;
  logic        stack_fault;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:255];

  stack_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_code       (op_code),
    .push_data     (push_data),
    .sp_in         (sp_in),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_re        (mem_re),
    .mem_rdata     (mem_rdata),
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .jump_valid    (jump_valid),
    .jump_addr     (jump_addr),
    .stack_command (stack_command),
    .stack_ctl     (stack_ctl),
    .op_done       (op_done),
    .op_err        (op_err),
    .stack_fault   (stack_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: synchronous write, read data valid the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic request(input logic [1:0] code, input logic [15:0] data, input logic [7:0] sp);
    op_valid  = 1'b1;
    op_code   = code;
    push_data = data;
    sp_in     = sp;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    op_code   = 2'd0;
    push_data = 16'h0000;
    sp_in     = 8'h3E;

    // Reset state
    cyc(); cyc();
    check("rst_ready", op_ready, 1);
    check("rst_strobes", {mem_we, mem_re, pop_valid, jump_valid, stack_command, op_done, op_err}, 0);
    check("rst_pop_data", pop_data, 16'h0000);
    check("rst_jump_addr", jump_addr, 16'h0000);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 16'h0000);
    check("rst_ctl_fault", {stack_ctl, stack_fault}, 0);
    rst_n = 1'b1;
    cyc();

    // PUSH 16'hBEEF at sp 3E
    request(2'd0, 16'hBEEF, 8'h3E);
    check("push_c0_ready", op_ready, 1);
    cyc(); op_valid = 1'b0;
    check("push_c1_wr", {mem_we, mem_re, mem_addr, mem_wdata}, {2'b10, 8'h3E, 8'hEF});
    check("push_c1_ctl", stack_ctl, 2'd0);
    cyc();
    check("push_c2_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h3F, 8'hBE});
    check("push_c2_cmd", {stack_command, op_done}, 0);
    cyc();
    check("push_c3_done", {stack_command, op_done, op_err, mem_we, op_ready}, 5'b11000);
    check("push_c3_ctl", stack_ctl, 2'd0);
    cyc();
    check("push_c4_idle", {op_ready, stack_command, op_done}, 3'b100);

    // POP with sp 3C reads back BEEF from 3E/3F
    sp_in = 8'h3C; request(2'd1, 16'h0000, 8'h3C);
    cyc(); op_valid = 1'b0;
    check("pop_c1_rd", {mem_re, mem_we, mem_addr}, {2'b10, 8'h3E});
    check("pop_c1_ctl", stack_ctl, 2'd1);
    cyc();
    check("pop_c2_rd", {mem_re, mem_addr}, {1'b1, 8'h3F});
    cyc();
    check("pop_c3_hold", {mem_re, pop_valid, pop_data}, {2'b00, 16'h0000});
    cyc();
    check("pop_c4_done", {pop_valid, jump_valid, stack_command, op_done, op_err}, 5'b10110);
    check("pop_c4_data", pop_data, 16'hBEEF);
    cyc();
    check("pop_c5_idle", {op_ready, pop_valid, stack_command}, 3'b100);
    check("pop_c5_held", pop_data, 16'hBEEF);

    // CALL 16'h0042 at sp 3E, then RET with sp 3C
    request(2'd2, 16'h0042, 8'h3E);
    cyc(); op_valid = 1'b0;
    check("call_c1_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h3E, 8'h42});
    check("call_ctl", stack_ctl, 2'd2);
    cyc();
    check("call_c2_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h3F, 8'h00});
    cyc();
    check("call_c3_done", {stack_command, jump_valid, pop_valid, stack_ctl}, {3'b100, 2'd2});
    cyc();
    request(2'd3, 16'h0000, 8'h3C);
    cyc(); op_valid = 1'b0;
    check("ret_ctl", stack_ctl, 2'd3);
    cyc(); cyc(); cyc();
    check("ret_c4_done", {jump_valid, pop_valid, stack_command, op_done}, 4'b1011);
    check("ret_jump_addr", jump_addr, 16'h0042);
    check("ret_pop_data", pop_data, 16'h0042);
    cyc();
    check("ret_c5_idle", {op_ready, jump_valid}, 2'b10);

`ifdef STACK_FAULT_EN
    // POP on empty stack is rejected
    request(2'd1, 16'h0000, 8'h3E);
    cyc(); op_valid = 1'b0;
    check("err_c1_done", {op_done, op_err, stack_fault}, 3'b111);
    check("err_c1_nomem", {mem_re, mem_we, stack_command}, 0);
    cyc();
    check("err_c2_idle", {op_ready, op_done, op_err, stack_fault}, 4'b1001);
    check("err_pop_kept", pop_data, 16'h0042);
    // A valid PUSH afterwards leaves the flag set
    request(2'd0, 16'h1111, 8'h3E);
    cyc(); op_valid = 1'b0;
    cyc(); cyc();
    check("err_sticky_done", {stack_command, op_err, stack_fault}, 3'b101);
    cyc();
`else
    // Without checks an empty-stack POP still reads 40/41 (both zero)
    request(2'd1, 16'h0000, 8'h3E);
    cyc(); op_valid = 1'b0;
    check("nf_pop_addr", {mem_re, mem_addr, op_err}, {1'b1, 8'h40, 1'b0});
    cyc(); cyc(); cyc();
    check("nf_pop_done", {pop_valid, op_err, stack_fault, pop_data}, {3'b100, 16'h0000});
    cyc();
    // PUSH at 8'hFF wraps the high byte to address 8'h00
    request(2'd0, 16'hA55A, 8'hFF);
    cyc(); op_valid = 1'b0;
    check("wrap_lo", {mem_addr, mem_wdata}, {8'hFF, 8'h5A});
    cyc();
    check("wrap_hi", {mem_addr, mem_wdata}, {8'h00, 8'hA5});
    cyc(); cyc();
`endif

    // Reset asserted during WR_HI aborts without stack_command
    request(2'd0, 16'h5555, 8'h3E);
    cyc(); op_valid = 1'b0;
    cyc();
    check("rst_mid_wrhi", {mem_we, mem_addr}, {1'b1, 8'h3F});
    rst_n = 1'b0;
    #1;
    check("rst_mid_abort", {op_ready, mem_we, stack_command, op_done}, 4'b1000);
    check("rst_mid_regs", {stack_ctl, stack_fault, pop_data}, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check("rst_mid_after", {op_ready, stack_command, op_done}, 3'b100);

    // Back-to-back: op_valid held across PUSH then POP
    request(2'd0, 16'h1234, 8'h3E);
    cyc(); op_code = 2'd1;
    check("b2b_c1_busy", {op_ready, mem_we, mem_addr}, {2'b01, 8'h3E});
    cyc();
    check("b2b_c2_busy", op_ready, 0);
    cyc();
    check("b2b_c3_done", {stack_command, op_ready, stack_ctl}, {2'b10, 2'd0});
    sp_in = 8'h3C;
    cyc();
    check("b2b_c4_accept", {op_ready, stack_command, mem_we, mem_re}, 4'b1000);
    cyc(); op_valid = 1'b0;
    check("b2b_c5_rd", {mem_re, mem_addr, stack_ctl, stack_command}, {1'b1, 8'h3E, 2'd1, 1'b0});
    cyc(); cyc(); cyc();
    check("b2b_pop_done", {pop_valid, stack_command, pop_data}, {2'b11, 16'h1234});
    cyc();
    check("b2b_final_idle", {op_ready, pop_valid}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
